// File: rtl/wb_defs.sv
// wb_defs: shared sizing and the queued-load entry layout for the
// register write-back stage.
//   DEPTH   - load queue entries
//   ADDR_W  - register number width
//   DATA_W  - register data width
//   wb_entry_t - {kill, dst, data}. A killed entry still occupies its slot
//                and pops in order, but it never reaches the register file.
package wb_defs;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 1 << ADDR_W;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = $clog2(DEPTH);

    typedef struct packed {
        logic              kill;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order load queue with per-entry kill-by-address.
//   clk, rst      - clock, asynchronous active-high reset
//   push          - enqueue push_entry (ignored when full)
//   push_entry    - entry to enqueue, kill bit supplied by the caller
//   pop           - drop the head entry (ignored when empty)
//   kill_en       - mark every live entry whose dst == kill_dst as killed
//   kill_dst      - register number for kill_en
//   head          - current head entry (only meaningful when count != 0)
//   count         - live entries, 0..DEPTH
//   busy_mask     - one-hot(dst) OR-ed over live, not-killed entries
module wb_fifo
    import wb_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  wb_entry_t         push_entry,
    input  logic              pop,
    input  logic              kill_en,
    input  logic [ADDR_W-1:0] kill_dst,
    output wb_entry_t         head,
    output logic [CNT_W-1:0]  count,
    output logic [NREGS-1:0]  busy_mask
);

    logic [ADDR_W-1:0] dst_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [DEPTH-1:0]  kill;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop  && (count != '0);

    // Payload storage carries no reset; vld/kill decide what is live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            dst_mem[wr_ptr]  <= push_entry.dst;
            data_mem[wr_ptr] <= push_entry.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld    <= '0;
            kill   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // The push slot is never live (no push when full), so the kill
            // scan and the push write cannot collide.
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && vld[i] && (dst_mem[i] == kill_dst))
                    kill[i] <= 1'b1;
            end
            if (do_push) begin
                vld[wr_ptr]  <= 1'b1;
                kill[wr_ptr] <= push_entry.kill;
                wr_ptr       <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                vld[rd_ptr] <= 1'b0;
                rd_ptr      <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        head.kill = kill[rd_ptr];
        head.dst  = dst_mem[rd_ptr];
        head.data = data_mem[rd_ptr];
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i] && !kill[i])
                busy_mask[dst_mem[i]] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges an unstallable ALU result stream and a queued load
// stream into a single registered register-file write port.
//   clk, rst                    - clock, asynchronous active-high reset
//   alu_valid/alu_dst/alu_data  - ALU result, never back-pressured
//   ld_valid/ld_dst/ld_data     - load result offer
//   ld_ready                    - load queue has room (registered count only)
//   regWrite/wr_add/writeData   - registered register-file write
//   busy_mask                   - registers with a live, unkilled queued load
//   q_count                     - queued load entries, 0..DEPTH
module reg_writeback
    import wb_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_dst,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_dst,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              regWrite,
    output logic [ADDR_W-1:0] wr_add,
    output logic [DATA_W-1:0] writeData,
    output logic [NREGS-1:0]  busy_mask,
    output logic [CNT_W-1:0]  q_count
);

    logic      alu_issue;
    logic      ld_accept;
    logic      pop;
    wb_entry_t push_entry;
    wb_entry_t head;

    // r0 is hardwired; an ALU write to it is simply not issued.
    assign alu_issue = alu_valid && (alu_dst != '0);

    // A pop in the same cycle does not open a slot: ready looks only at the
    // registered count. Held low during reset so nothing is taken.
    assign ld_ready  = !rst && (q_count != CNT_W'(DEPTH));
    assign ld_accept = ld_valid && ld_ready;

    // The ALU owns the write port whenever it issues; the queue drains only
    // in the gaps.
    assign pop = !alu_issue && (q_count != '0);

    // A load colliding with a same-cycle ALU write to the same register is
    // the older value, so it goes in already dead. Loads to r0 likewise.
    always_comb begin
        push_entry.kill = (ld_dst == '0) || (alu_issue && (ld_dst == alu_dst));
        push_entry.dst  = ld_dst;
        push_entry.data = ld_data;
    end

    wb_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (ld_accept),
        .push_entry (push_entry),
        .pop        (pop),
        .kill_en    (alu_issue),
        .kill_dst   (alu_dst),
        .head       (head),
        .count      (q_count),
        .busy_mask  (busy_mask)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regWrite  <= 1'b0;
            wr_add    <= '0;
            writeData <= '0;
        end else if (alu_issue) begin
            regWrite  <= 1'b1;
            wr_add    <= alu_dst;
            writeData <= alu_data;
        end else if (pop && !head.kill) begin
            regWrite  <= 1'b1;
            wr_add    <= head.dst;
            writeData <= head.data;
        end else begin
            // Killed pops and idle cycles: no write, address/data hold.
            regWrite  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_dst;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic [4:0]  ld_dst;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        regWrite;
    logic [4:0]  wr_add;
    logic [31:0] writeData;
    logic [31:0] busy_mask;
    logic [2:0]  q_count;

    int n_cmp  = 0;
    int n_fail = 0;

    reg_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_dst   (alu_dst),
        .alu_data  (alu_data),
        .ld_valid  (ld_valid),
        .ld_dst    (ld_dst),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .regWrite  (regWrite),
        .wr_add    (wr_add),
        .writeData (writeData),
        .busy_mask (busy_mask),
        .q_count   (q_count)
    );

    always #5 clk = ~clk;

    // One clock: returns 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; alu_valid = 0; alu_dst = 0; alu_data = 0;
        ld_valid = 0; ld_dst = 0; ld_data = 0;
        #3;
        n_cmp++; if (regWrite !== 1'b0) begin $display("FAIL rst_we got %0b want 0", regWrite); n_fail++; end
        n_cmp++; if (wr_add !== 5'd0) begin $display("FAIL rst_addr got %0d want 0", wr_add); n_fail++; end
        n_cmp++; if (writeData !== 32'd0) begin $display("FAIL rst_data got %h want 0", writeData); n_fail++; end
        n_cmp++; if (q_count !== 3'd0) begin $display("FAIL rst_cnt got %0d want 0", q_count); n_fail++; end
        n_cmp++; if (busy_mask !== 32'd0) begin $display("FAIL rst_busy got %h want 0", busy_mask); n_fail++; end
        n_cmp++; if (ld_ready !== 1'b0) begin $display("FAIL rst_rdy got %0b want 0", ld_ready); n_fail++; end
        step(); step();
        rst = 1'b0;
        #1;
        n_cmp++; if (ld_ready !== 1'b1) begin $display("FAIL rel_rdy got %0b want 1", ld_ready); n_fail++; end
    endtask

    task automatic test_alu();
        alu_valid = 1; alu_dst = 5; alu_data = 32'hDEADBEEF;
        step();
        alu_valid = 0;
        n_cmp++; if (regWrite !== 1'b1) begin $display("FAIL alu_we got %0b want 1", regWrite); n_fail++; end
        n_cmp++; if (wr_add !== 5'd5) begin $display("FAIL alu_addr got %0d want 5", wr_add); n_fail++; end
        n_cmp++; if (writeData !== 32'hDEADBEEF) begin $display("FAIL alu_data got %h want deadbeef", writeData); n_fail++; end
        step();
        n_cmp++; if (regWrite !== 1'b0) begin $display("FAIL alu_idle_we got %0b want 0", regWrite); n_fail++; end
        n_cmp++; if (wr_add !== 5'd5 || writeData !== 32'hDEADBEEF) begin
            $display("FAIL alu_hold got %0d/%h want 5/deadbeef", wr_add, writeData); n_fail++; end
    endtask

    task automatic test_load();
        ld_valid = 1; ld_dst = 3; ld_data = 32'h11;
        step();
        ld_valid = 0;
        n_cmp++; if (busy_mask !== 32'h8) begin $display("FAIL ld_busy got %h want 8", busy_mask); n_fail++; end
        n_cmp++; if (q_count !== 3'd1) begin $display("FAIL ld_cnt got %0d want 1", q_count); n_fail++; end
        n_cmp++; if (regWrite !== 1'b0) begin $display("FAIL ld_early_we got %0b want 0", regWrite); n_fail++; end
        step();
        n_cmp++; if (regWrite !== 1'b1 || wr_add !== 5'd3 || writeData !== 32'h11) begin
            $display("FAIL ld_wr got we=%0b %0d/%h want 1 3/11", regWrite, wr_add, writeData); n_fail++; end
        n_cmp++; if (busy_mask !== 32'd0 || q_count !== 3'd0) begin
            $display("FAIL ld_drain got busy=%h cnt=%0d want 0/0", busy_mask, q_count); n_fail++; end
        step();
        n_cmp++; if (regWrite !== 1'b0) begin $display("FAIL ld_after_we got %0b want 0", regWrite); n_fail++; end
    endtask

    task automatic test_back_to_back();
        alu_valid = 1; alu_dst = 9; alu_data = 32'h99;
        ld_valid = 1;
        for (int k = 1; k <= 4; k++) begin
            ld_dst = 5'(k); ld_data = 32'h100 + 32'(k);
            step();
        end
        // Offer a fifth load while full: must not be taken.
        ld_dst = 5'd5; ld_data = 32'h105;
        n_cmp++; if (q_count !== 3'd4) begin $display("FAIL full_cnt got %0d want 4", q_count); n_fail++; end
        n_cmp++; if (ld_ready !== 1'b0) begin $display("FAIL full_rdy got %0b want 0", ld_ready); n_fail++; end
        n_cmp++; if (busy_mask !== 32'h1E) begin $display("FAIL full_busy got %h want 1e", busy_mask); n_fail++; end
        n_cmp++; if (regWrite !== 1'b1 || wr_add !== 5'd9) begin
            $display("FAIL full_alu got we=%0b addr=%0d want 1 9", regWrite, wr_add); n_fail++; end
        step();
        ld_valid = 0;
        n_cmp++; if (q_count !== 3'd4) begin $display("FAIL full_hold got %0d want 4", q_count); n_fail++; end
        alu_valid = 0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_cmp++; if (regWrite !== 1'b1 || wr_add !== 5'(k) || writeData !== 32'h100 + 32'(k)) begin
                $display("FAIL drain%0d got we=%0b %0d/%h want 1 %0d/%h", k, regWrite, wr_add, writeData, k, 32'h100 + 32'(k)); n_fail++; end
            n_cmp++; if (q_count !== 3'(4 - k) || ld_ready !== 1'b1) begin
                $display("FAIL drain%0d_cnt got cnt=%0d rdy=%0b want %0d 1", k, q_count, ld_ready, 4 - k); n_fail++; end
        end
        step();
        n_cmp++; if (regWrite !== 1'b0 || busy_mask !== 32'd0) begin
            $display("FAIL drain_end got we=%0b busy=%h want 0 0", regWrite, busy_mask); n_fail++; end
    endtask

    task automatic test_kill();
        ld_valid = 1; ld_dst = 7; ld_data = 32'hAA;
        step();
        ld_valid = 0;
        n_cmp++; if (busy_mask !== 32'h80) begin $display("FAIL kill_busy got %h want 80", busy_mask); n_fail++; end
        alu_valid = 1; alu_dst = 7; alu_data = 32'hBB;
        step();
        alu_valid = 0;
        n_cmp++; if (regWrite !== 1'b1 || wr_add !== 5'd7 || writeData !== 32'hBB) begin
            $display("FAIL kill_alu got we=%0b %0d/%h want 1 7/bb", regWrite, wr_add, writeData); n_fail++; end
        n_cmp++; if (busy_mask !== 32'd0 || q_count !== 3'd1) begin
            $display("FAIL kill_mark got busy=%h cnt=%0d want 0 1", busy_mask, q_count); n_fail++; end
        step();
        n_cmp++; if (regWrite !== 1'b0 || q_count !== 3'd0 || writeData !== 32'hBB) begin
            $display("FAIL kill_pop got we=%0b cnt=%0d data=%h want 0 0 bb", regWrite, q_count, writeData); n_fail++; end
    endtask

    task automatic test_same_cycle();
        alu_valid = 1; alu_dst = 6; alu_data = 32'hA1;
        ld_valid = 1; ld_dst = 6; ld_data = 32'hB2;
        step();
        alu_valid = 0; ld_valid = 0;
        n_cmp++; if (regWrite !== 1'b1 || wr_add !== 5'd6 || writeData !== 32'hA1) begin
            $display("FAIL same_alu got we=%0b %0d/%h want 1 6/a1", regWrite, wr_add, writeData); n_fail++; end
        n_cmp++; if (q_count !== 3'd1 || busy_mask !== 32'd0) begin
            $display("FAIL same_q got cnt=%0d busy=%h want 1 0", q_count, busy_mask); n_fail++; end
        step();
        n_cmp++; if (regWrite !== 1'b0 || q_count !== 3'd0 || writeData !== 32'hA1) begin
            $display("FAIL same_pop got we=%0b cnt=%0d data=%h want 0 0 a1", regWrite, q_count, writeData); n_fail++; end
    endtask

    task automatic test_zero();
        alu_valid = 1; alu_dst = 0; alu_data = 32'h55;
        ld_valid = 1; ld_dst = 0; ld_data = 32'h66;
        step();
        alu_valid = 0; ld_valid = 0;
        n_cmp++; if (regWrite !== 1'b0 || q_count !== 3'd1 || busy_mask !== 32'd0) begin
            $display("FAIL zero_1 got we=%0b cnt=%0d busy=%h want 0 1 0", regWrite, q_count, busy_mask); n_fail++; end
        step();
        n_cmp++; if (regWrite !== 1'b0 || q_count !== 3'd0) begin
            $display("FAIL zero_2 got we=%0b cnt=%0d want 0 0", regWrite, q_count); n_fail++; end
    endtask

    task automatic test_reset_mid();
        alu_valid = 1; alu_dst = 20; alu_data = 32'h20;
        ld_valid = 1;
        for (int k = 0; k < 3; k++) begin
            ld_dst = 5'(10 + k); ld_data = 32'h200 + 32'(k);
            step();
        end
        alu_valid = 0; ld_valid = 0;
        n_cmp++; if (q_count !== 3'd3) begin $display("FAIL rm_cnt got %0d want 3", q_count); n_fail++; end
        step();
        n_cmp++; if (regWrite !== 1'b1 || wr_add !== 5'd10 || q_count !== 3'd2) begin
            $display("FAIL rm_first got we=%0b addr=%0d cnt=%0d want 1 10 2", regWrite, wr_add, q_count); n_fail++; end
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (regWrite !== 1'b0 || wr_add !== 5'd0 || writeData !== 32'd0) begin
            $display("FAIL rm_out got we=%0b %0d/%h want 0 0/0", regWrite, wr_add, writeData); n_fail++; end
        n_cmp++; if (q_count !== 3'd0 || busy_mask !== 32'd0 || ld_ready !== 1'b0) begin
            $display("FAIL rm_q got cnt=%0d busy=%h rdy=%0b want 0 0 0", q_count, busy_mask, ld_ready); n_fail++; end
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            n_cmp++; if (regWrite !== 1'b0 || q_count !== 3'd0 || ld_ready !== 1'b1) begin
                $display("FAIL rm_post%0d got we=%0b cnt=%0d rdy=%0b want 0 0 1", k, regWrite, q_count, ld_ready); n_fail++; end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_back_to_back();
        test_kill();
        test_same_cycle();
        test_zero();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
